// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter
// and the backing memory.
interface datamem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [63:0] p0_addr;
  logic [63:0] p0_wdata;
  logic [3:0]  p0_size;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [63:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [63:0] p1_addr;
  logic [63:0] p1_wdata;
  logic [3:0]  p1_size;
  logic        p1_lock;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [63:0] p1_rdata;
  logic        p1_err;

  logic [63:0] mem_address;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [63:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_read_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_address, mem_write_enable, mem_read_enable,
    output mem_write_data, mem_xfer_size,
    input  mem_read_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_address, mem_write_enable, mem_read_enable,
    input  mem_write_data, mem_xfer_size,
    output mem_read_data
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port data-memory arbiter: port 0 priority, port 1 starvation
// guard and lock, access screening and registered masked responses.
module datamem_arbiter #(
  parameter int MEM_SIZE     = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  datamem_arbiter_if.slave bus
);

  typedef enum logic {ARB, LOCK1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_starve;

  logic        w_g0;
  logic        w_g1;
  logic        w_gnt;
  logic        w_we;
  logic [63:0] w_addr;
  logic [63:0] w_wdata;
  logic [3:0]  w_size;
  logic        w_sz_ok;
  logic        w_align;
  logic [64:0] w_end;
  logic        w_inb;
  logic        w_legal;
  logic [63:0] w_mask;
  logic [63:0] w_rdata;
  logic        w_sat;

  logic        r_rv0;
  logic        r_rv1;
  logic        r_err0;
  logic        r_err1;
  logic [63:0] r_rd0;
  logic [63:0] r_rd1;

  assign w_sat = (r_starve == 4'(STARVE_LIMIT));

  always_comb begin
    w_g0   = 1'b0;
    w_g1   = 1'b0;
    w_next = r_state;
    if (!reset) begin
      unique case (r_state)
        ARB: begin
          if (bus.p0_req && !(bus.p1_req && w_sat)) begin
            w_g0 = 1'b1;
          end else if (bus.p1_req) begin
            w_g1 = 1'b1;
            if (bus.p1_lock) w_next = LOCK1;
          end
        end
        LOCK1: begin
          if (bus.p1_req) begin
            w_g1 = 1'b1;
            if (!bus.p1_lock) w_next = ARB;
          end else begin
            w_next = ARB;
          end
        end
        default: w_next = ARB;
      endcase
    end
  end

  assign w_gnt   = w_g0 | w_g1;
  assign w_we    = w_g1 ? bus.p1_we    : bus.p0_we;
  assign w_addr  = w_g1 ? bus.p1_addr  : bus.p0_addr;
  assign w_wdata = w_g1 ? bus.p1_wdata : bus.p0_wdata;
  assign w_size  = w_g1 ? bus.p1_size  : bus.p0_size;

  assign w_sz_ok = (w_size == 4'd1) | (w_size == 4'd2) |
                   (w_size == 4'd4) | (w_size == 4'd8);
  assign w_align = ((w_addr & (64'(w_size) - 64'd1)) == 64'd0);
  // 65-bit end address so a huge base cannot wrap into range
  assign w_end   = {1'b0, w_addr} + 65'(w_size);
  assign w_inb   = (w_end <= 65'(MEM_SIZE));
  assign w_legal = w_sz_ok & w_align & w_inb;

  assign bus.mem_address      = w_addr;
  assign bus.mem_write_data   = w_wdata;
  assign bus.mem_xfer_size    = w_size;
  assign bus.mem_write_enable = w_gnt & w_legal & w_we;
  assign bus.mem_read_enable  = w_gnt & w_legal & ~w_we;

  always_comb begin
    w_mask = '1;
    case (w_size)
      4'd1:    w_mask = 64'h0000_0000_0000_00FF;
      4'd2:    w_mask = 64'h0000_0000_0000_FFFF;
      4'd4:    w_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_mask = '1;
    endcase
  end

  assign w_rdata = (w_legal && !w_we) ?
                   (bus.mem_read_data & w_mask) : 64'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB;
      r_starve <= 4'd0;
    end else begin
      r_state <= w_next;
      if (!bus.p1_req || w_g1) r_starve <= 4'd0;
      else if (!w_sat)         r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      r_rd0  <= 64'd0;
      r_rd1  <= 64'd0;
    end else begin
      r_rv0  <= w_g0;
      r_rv1  <= w_g1;
      r_err0 <= w_g0 & ~w_legal;
      r_err1 <= w_g1 & ~w_legal;
      if (w_g0) r_rd0 <= w_rdata;
      if (w_g1) r_rd1 <= w_rdata;
    end
  end

  assign bus.p0_gnt    = w_g0;
  assign bus.p1_gnt    = w_g1;
  assign bus.p0_rvalid = r_rv0;
  assign bus.p1_rvalid = r_rv1;
  assign bus.p0_err    = r_err0;
  assign bus.p1_err    = r_err1;
  assign bus.p0_rdata  = r_rd0;
  assign bus.p1_rdata  = r_rd1;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a 64-byte
// little-endian memory model behind it.
module tb_datamem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] mem [0:63];

  datamem_arbiter_if bus();

  datamem_arbiter #(
    .MEM_SIZE(64),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_read_data = '0;
    for (int i = 0; i < 8; i++)
      bus.mem_read_data[i*8 +: 8] =
        mem[6'(bus.mem_address[5:0] + 6'(i))];
  end

  always @(posedge clk) begin
    if (bus.mem_write_enable)
      for (int i = 0; i < 8; i++)
        if (i < int'(bus.mem_xfer_size))
          mem[6'(bus.mem_address[5:0] + 6'(i))] <=
            bus.mem_write_data[i*8 +: 8];
  end

  task automatic drv0(input logic req, input logic we,
                      input logic [63:0] addr,
                      input logic [63:0] wd,
                      input logic [3:0] size);
    bus.p0_req   = req;
    bus.p0_we    = we;
    bus.p0_addr  = addr;
    bus.p0_wdata = wd;
    bus.p0_size  = size;
  endtask

  task automatic drv1(input logic req, input logic we,
                      input logic [63:0] addr,
                      input logic [63:0] wd,
                      input logic [3:0] size,
                      input logic lock);
    bus.p1_req   = req;
    bus.p1_we    = we;
    bus.p1_addr  = addr;
    bus.p1_wdata = wd;
    bus.p1_size  = size;
    bus.p1_lock  = lock;
  endtask

  task automatic idle();
    drv0(0, 0, 0, 0, 8);
    drv1(0, 0, 0, 0, 8, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv0(1, 0, 8, 0, 8);
    drv1(1, 0, 0, 0, 8, 0);
    @(negedge clk); #1;
    n_vec++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable,
         bus.mem_read_enable} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_gnt: got %b want 0000",
        {bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable,
         bus.mem_read_enable});
    end
    n_vec++;
    if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err,
         bus.p0_rdata, bus.p1_rdata} !== 132'd0) begin
      n_err++;
      $display("FAIL reset_resp: got rv=%b%b err=%b%b rd=%h/%h want 0",
        bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err,
        bus.p0_rdata, bus.p1_rdata);
    end
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drv0(1, 1, 8, 64'h1122334455667788, 8); #1;
    n_vec++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable,
         bus.mem_read_enable, bus.mem_address} !== {4'b1010, 64'd8}) begin
      n_err++;
      $display("FAIL wr_gnt: got %b addr %h want 1010 addr 8",
        {bus.p0_gnt, bus.p1_gnt, bus.mem_write_enable,
         bus.mem_read_enable}, bus.mem_address);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.p0_rvalid, bus.p0_err, bus.p1_rvalid, bus.p0_rdata}
        !== {3'b100, 64'd0}) begin
      n_err++;
      $display("FAIL wr_resp: got %b rd %h want 100 rd 0",
        {bus.p0_rvalid, bus.p0_err, bus.p1_rvalid}, bus.p0_rdata);
    end
    @(negedge clk);
    drv0(1, 0, 8, 0, 8); #1;
    n_vec++;
    if ({bus.p0_gnt, bus.mem_write_enable, bus.mem_read_enable}
        !== 3'b101) begin
      n_err++;
      $display("FAIL rd_gnt: got %b want 101",
        {bus.p0_gnt, bus.mem_write_enable, bus.mem_read_enable});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata}
        !== {2'b10, 64'h1122334455667788}) begin
      n_err++;
      $display("FAIL raw_read: got %b rd %h want 10 rd 1122334455667788",
        {bus.p0_rvalid, bus.p0_err}, bus.p0_rdata);
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    n_vec++;
    if (bus.p0_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rv_pulse: got %b want 0", bus.p0_rvalid);
    end
  endtask

  task automatic test_size_mask();
    logic [63:0] a [3];
    logic [3:0]  s [3];
    logic [63:0] e [3];
    a = '{64'd12, 64'd9, 64'd12};
    s = '{4'd2, 4'd1, 4'd4};
    e = '{64'h3344, 64'h77, 64'h11223344};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drv0(1, 0, a[k], 0, s[k]);
      @(posedge clk); #1;
      n_vec++;
      if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata}
          !== {2'b10, e[k]}) begin
        n_err++;
        $display("FAIL mask%0d: got %b rd %h want 10 rd %h",
          k, {bus.p0_rvalid, bus.p0_err}, bus.p0_rdata, e[k]);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_starve();
    logic x1;
    @(negedge clk);
    drv0(1, 0, 8, 0, 8);
    drv1(1, 0, 16, 0, 8, 0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      x1 = ((c % 5) == 4);
      n_vec++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {~x1, x1}) begin
        n_err++;
        $display("FAIL starve_gnt c%0d: got %b%b want %b%b",
          c, bus.p0_gnt, bus.p1_gnt, ~x1, x1);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({bus.p0_rvalid, bus.p1_rvalid} !== {~x1, x1}) begin
        n_err++;
        $display("FAIL starve_rv c%0d: got %b%b want %b%b",
          c, bus.p0_rvalid, bus.p1_rvalid, ~x1, x1);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_illegal();
    logic [63:0] a [4];
    logic [3:0]  s [4];
    logic        bad [4];
    a   = '{64'd3, 64'd60, 64'd0, 64'd56};
    s   = '{4'd4, 4'd8, 4'd3, 4'd8};
    bad = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drv1(1, 0, a[k], 0, s[k], 0); #1;
      n_vec++;
      if ({bus.p1_gnt, bus.p0_gnt, bus.mem_write_enable,
           bus.mem_read_enable} !== {3'b100, ~bad[k]}) begin
        n_err++;
        $display("FAIL ill_gnt%0d: got %b want %b", k,
          {bus.p1_gnt, bus.p0_gnt, bus.mem_write_enable,
           bus.mem_read_enable}, {3'b100, ~bad[k]});
      end
      @(posedge clk); #1;
      n_vec++;
      if ({bus.p1_rvalid, bus.p1_err, bus.p0_rvalid, bus.p1_rdata}
          !== {1'b1, bad[k], 1'b0, 64'd0}) begin
        n_err++;
        $display("FAIL ill_resp%0d: got %b rd %h want %b rd 0", k,
          {bus.p1_rvalid, bus.p1_err, bus.p0_rvalid}, bus.p1_rdata,
          {1'b1, bad[k], 1'b0});
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lock();
    logic       p0r [9];
    logic       p1r [9];
    logic       lk  [9];
    logic [1:0] eg  [9];
    p0r = '{0, 1, 1, 1, 1, 1, 0, 1, 1};
    p1r = '{1, 1, 1, 1, 1, 0, 1, 0, 0};
    lk  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    eg  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
            2'b10, 2'b01, 2'b00, 2'b10};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drv0(p0r[c], 0, 0, 0, 8);
      drv1(p1r[c], 0, 0, 0, 8, lk[c]); #1;
      n_vec++;
      if ({bus.p0_gnt, bus.p1_gnt} !== eg[c]) begin
        n_err++;
        $display("FAIL lock c%0d: got %b%b want %b",
          c, bus.p0_gnt, bus.p1_gnt, eg[c]);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    logic x1;
    @(negedge clk);
    drv0(1, 0, 8, 0, 8);
    drv1(1, 0, 0, 0, 8, 0);
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (bus.p0_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_gnt: got %b want 1", bus.p0_gnt);
    end
    reset = 1'b1; #1;
    n_vec++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.mem_read_enable} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_gnt: got %b want 000",
        {bus.p0_gnt, bus.p1_gnt, bus.mem_read_enable});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_drop: got %b%b want 00",
        bus.p0_rvalid, bus.p1_rvalid);
    end
    @(negedge clk);
    reset = 1'b0; #1;
    n_vec++;
    if (bus.p0_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rel_rv: got %b want 0", bus.p0_rvalid);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      x1 = (c == 4);
      n_vec++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {~x1, x1}) begin
        n_err++;
        $display("FAIL rst_after c%0d: got %b%b want %b%b",
          c, bus.p0_gnt, bus.p1_gnt, ~x1, x1);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.p1_rvalid, bus.p1_rdata} !== {1'b1, 64'd0}) begin
      n_err++;
      $display("FAIL rst_p1_rd: got %b %h want 1 0",
        bus.p1_rvalid, bus.p1_rdata);
    end
    @(negedge clk);
    drv1(0, 0, 0, 0, 8, 0);
    @(posedge clk); #1;
    n_vec++;
    if ({bus.p0_rvalid, bus.p0_rdata}
        !== {1'b1, 64'h1122334455667788}) begin
      n_err++;
      $display("FAIL rst_p0_rd: got %b %h want 1 1122334455667788",
        bus.p0_rvalid, bus.p0_rdata);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    bus.p1_lock = 1'b0;
    test_reset();
    test_write_read();
    test_size_mask();
    test_starve();
    test_illegal();
    test_lock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_err);
    $finish;
  end

endmodule
